// File: rtl/spram_uart_dump_pkg.sv
// Shared definitions for the SPRAM-to-UART dump engine and other UART byte producers.
package spram_uart_dump_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND_LO,
        S_GAP_LO,
        S_SEND_HI,
        S_GAP_HI
    } state_t;

    // Frame bits times clocks per bit, plus two guard cycles between frames.
    function automatic int gap_cycles(input int bit_width, input int clock_hz, input int baud);
        return bit_width * (clock_hz / baud) + 2;
    endfunction

endpackage

// File: rtl/uart_tx_pacer.sv
// Loadable down-counter that spaces UART send pulses; expired while the count is zero.
module uart_tx_pacer #(
    parameter int GAP_CYCLES = 112,
    parameter int W          = $clog2(GAP_CYCLES + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/spram_uart_dump.sv
// Streams a range of 16-bit SPRAM words out as UART bytes, low byte first, self-paced.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_FETCH   | waiting for the first word's read latency
// S_SEND_LO | low byte handed to the uart
// S_GAP_LO  | pacing the low-byte frame
// S_SEND_HI | high byte handed to the uart, next address issued
// S_GAP_HI  | pacing the high-byte frame while the next word is prefetched
module spram_uart_dump
    import spram_uart_dump_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 40000000,
    parameter int BAUD_RATE     = 4000000,
    parameter int BIT_WIDTH     = 11,
    parameter int RD_LATENCY    = 2,
    parameter int GAP_CYCLES    = gap_cycles(BIT_WIDTH, CLOCK_FREQ_HZ, BAUD_RATE)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic [15:0] word_count,
    output logic [15:0] ram_addr,
    input  logic [15:0] ram_rd_data,
    output logic        tx_send,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        done
);

    localparam int PW = $clog2(GAP_CYCLES + 1);
    localparam int FW = $clog2(RD_LATENCY + 2);
    localparam logic [FW-1:0] FETCH_LAST = FW'(RD_LATENCY);
    // Load is registered, so the pacer starts one cycle after the send pulse.
    localparam logic [PW-1:0] PACE_LOAD  = PW'(GAP_CYCLES - 2);

    state_t        state;
    logic [15:0]   remaining;
    logic [15:0]   word;
    logic [FW-1:0] fcnt;
    logic          pacer_load;
    logic          expired;

    uart_tx_pacer #(.GAP_CYCLES(GAP_CYCLES), .W(PW)) u_pacer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (pacer_load),
        .load_value (PACE_LOAD),
        .expired    (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ram_addr   <= '0;
            tx_send    <= 1'b0;
            tx_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            remaining  <= '0;
            word       <= '0;
            fcnt       <= '0;
            pacer_load <= 1'b0;
        end else begin
            tx_send    <= 1'b0;
            done       <= 1'b0;
            pacer_load <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done) begin
                        if (word_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            ram_addr  <= base_addr;
                            remaining <= word_count;
                            busy      <= 1'b1;
                            fcnt      <= '0;
                            state     <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (fcnt == FETCH_LAST) begin
                        word       <= ram_rd_data;
                        tx_data    <= ram_rd_data[7:0];
                        tx_send    <= 1'b1;
                        pacer_load <= 1'b1;
                        state      <= S_SEND_LO;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                S_SEND_LO: state <= S_GAP_LO;
                S_GAP_LO: begin
                    if (expired) begin
                        tx_data    <= word[15:8];
                        tx_send    <= 1'b1;
                        pacer_load <= 1'b1;
                        remaining  <= remaining - 1'b1;
                        if (remaining != 16'd1) ram_addr <= ram_addr + 1'b1;
                        fcnt       <= '0;
                        state      <= S_SEND_HI;
                    end
                end
                S_SEND_HI: begin
                    fcnt  <= fcnt + 1'b1;
                    state <= S_GAP_HI;
                end
                S_GAP_HI: begin
                    if (fcnt == FETCH_LAST) begin
                        word <= ram_rd_data;
                        fcnt <= fcnt + 1'b1;
                    end else if (fcnt < FETCH_LAST) begin
                        fcnt <= fcnt + 1'b1;
                    end
                    if (expired) begin
                        if (remaining != '0) begin
                            tx_data    <= word[7:0];
                            tx_send    <= 1'b1;
                            pacer_load <= 1'b1;
                            state      <= S_SEND_LO;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/spram_uart_dump.md
# spram_uart_dump

Streams a contiguous range of 16-bit words from the single-port SPRAM out through the `uart` transmit interface, low byte first, as a byte stream. It is the read-back counterpart of the SPRAM initialisation/write FSM in the top level. It lets the host dump memory contents, such as lifting results written by the `jpeg` stages, over the 4 Mbaud link. The `uart` exposes no busy flag, so this block paces bytes itself with a frame-length counter.

## Interface
Parameters:
- `CLOCK_FREQ_HZ`, default 40000000: `clk` frequency.
- `BAUD_RATE`, default 4000000: UART bit rate.
- `BIT_WIDTH`, default 11: bits per UART frame, including start, stop and parity.
- `RD_LATENCY`, default 2: cycles from `ram_addr` change to valid `ram_rd_data`.
- `GAP_CYCLES`, default BIT_WIDTH*CLOCK_FREQ_HZ/BAUD_RATE + 2 = 112: spacing between `tx_send` pulses. Must satisfy GAP_CYCLES > RD_LATENCY + 2.

Ports:
- `clk`, in, 1: single clock (`s_clk` domain).
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: 1-cycle request pulse; ignored while `busy`.
- `base_addr`, in, 16: first word address, sampled on `start`.
- `word_count`, in, 16: number of words, sampled on `start`; 0 means no transfer.
- `ram_addr`, out, 16: SPRAM read address (registered).
- `ram_rd_data`, in, 16: SPRAM DATAOUT.
- `tx_send`, out, 1: 1-cycle pulse to `uart.send`.
- `tx_data`, out, 8: byte to `uart.tx_data`; stable from `tx_send` until the next `tx_send`.
- `busy`, out, 1: transfer in progress.
- `done`, out, 1: 1-cycle pulse when the last byte's frame has completed.

## Operation
- Reset values: `ram_addr`=0, `tx_send`=0, `tx_data`=0, `busy`=0, `done`=0, state IDLE, all counters 0.
- States:
  - **IDLE**: on `start`, latch `base_addr`/`word_count`. If `word_count`=0, pulse `done` on the next cycle and stay in IDLE. Otherwise drive `ram_addr`=base, set `busy`, go to FETCH.
  - **FETCH**: wait RD_LATENCY cycles, capture `ram_rd_data` into the word register, go to SEND_LO.
  - **SEND_LO**: `tx_data`=word[7:0], pulse `tx_send`, load the pacer, go to GAP_LO.
  - **GAP_LO**: wait for pacer expiry, go to SEND_HI.
  - **SEND_HI**: `tx_data`=word[15:8], pulse `tx_send`, load the pacer. If words remain, increment `ram_addr`. Go to GAP_HI.
  - **GAP_HI**: the next word is prefetched RD_LATENCY cycles after the address increment and captured into the word register. On pacer expiry, go to SEND_LO if words remain. Otherwise pulse `done`, clear `busy`, go to IDLE.
- Address arithmetic is modulo 2^16; base 0xFFFF with count 2 reads 0xFFFF then 0x0000.
- The remaining-word counter is 16-bit and decrements at each SEND_HI.
- A `start` while `busy` has no effect. A `start` in the same cycle as the `done` pulse is ignored; it is accepted from the following cycle.
- `rst_n` asserted mid-transfer aborts immediately: all outputs return to reset values and no `done` is issued. A byte already handed to `uart` completes on the line.

## Timing
- `start` sampled at edge E0 → `ram_addr`=base after E0 → first `tx_send` high in cycle E0+RD_LATENCY+1. With default RD_LATENCY=2, that is 3 cycles of latency.
- Consecutive `tx_send` pulses are exactly GAP_CYCLES apart, including across word boundaries, because the prefetch hides the memory latency.
- A transfer of N words produces 2N pulses. `done` fires GAP_CYCLES after the last pulse.
- Total cycles from `start` to `done` = RD_LATENCY + 1 + 2N·GAP_CYCLES.
- `busy` rises the cycle after `start` and falls in the same cycle as `done`.

## Structure
- Shared package holds:
  - the state encoding;
  - the default GAP_CYCLES derivation function (frame bits × clocks per bit + 2 guard cycles), also usable by other UART producers.
- One sub-module, `uart_tx_pacer`: a loadable down-counter with an `expired` flag and a width sized by clog2(GAP_CYCLES+1).

## Test plan
- SPRAM model with 2-cycle latency: [0]=0x0001, [1]=0x0002, [2]=0x0004, [3]=0x0007. Start base=0, count=4 → bytes 01 00 02 00 04 00 07 00. Pulses 112 cycles apart. `done` at start+3+8·112.
- Start with base=0xFFFF, count=2, memory [0xFFFF]=0xBEEF, [0]=0x1234 → bytes EF BE 34 12, showing address wrap.
- Start with count=0 → no `tx_send`; `done` pulses one cycle later; `busy` stays 0.
- Second `start` during transfer (base=5) → ignored; byte stream and `done` time unchanged from the original request.
- Deassert `rst_n` during GAP_LO of word 2 → outputs immediately return to reset values; no further `tx_send`; no `done`; a subsequent `start` works normally.
- Loopback through `uart` at 4 Mbaud into a receiver model → all 2N bytes received intact with no overrun.
